// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-ported unified memory between the instruction-fetch path
// (IF) and the load/store path (D). Only one transaction is in flight at a
// time. When both sides request together, the side that did not win last
// time is granted, so the two sides alternate. The memory read latency is the
// fixed parameter LATENCY.
//
// Parameters:
//   LATENCY    cycles from mem_en to valid mem_rdata, legal range 1..15
//
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   if_req/if_addr                 fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata      fetch grant, read-data pulse, read data
//   d_req/d_we/d_addr/d_wdata      data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata         data grant, load-data pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe, write enable, address, write data
//   mem_rdata                      memory read data, valid LATENCY cycles after mem_en
module mem_port_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // The counter is loaded with LATENCY-1. The rvalid cycle is the cycle in
  // which the counter reads 0.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_is_data_q, last_is_data_d;   // 1: D won most recently
  logic       owner_is_data_q, owner_is_data_d; // owner of the in-flight read
  logic       pick_if, pick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 4'd0;
      last_is_data_q  <= 1'b1;  // IF wins the first tie after reset
      owner_is_data_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_is_data_q  <= last_is_data_d;
      owner_is_data_q <= owner_is_data_d;
    end
  end

  // D wins when it is the only requester, or when both request and IF won last.
  assign pick_d  = d_req && (!if_req || !last_is_data_q);
  assign pick_if = if_req && !pick_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_is_data_d  = last_is_data_q;
    owner_is_data_d = owner_is_data_q;
    if_gnt          = 1'b0;
    d_gnt           = 1'b0;
    if_rvalid       = 1'b0;
    d_rvalid        = 1'b0;
    if_rdata        = 32'h0;
    d_rdata         = 32'h0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = 32'h0;
    mem_wdata       = 32'h0;

    // Outputs are forced quiet while reset is asserted, even if requests are
    // already present on the inputs.
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_if) begin
            if_gnt          = 1'b1;
            mem_en          = 1'b1;
            mem_addr        = if_addr;
            last_is_data_d  = 1'b0;
            owner_is_data_d = 1'b0;
            cnt_d           = CNT_LOAD;
            state_d         = S_WAIT;
          end else if (pick_d) begin
            d_gnt          = 1'b1;
            mem_en         = 1'b1;
            mem_we         = d_we;
            mem_addr       = d_addr;
            mem_wdata      = d_wdata;
            last_is_data_d = 1'b1;
            // A store commits on this edge and needs no return path, so the
            // block stays in IDLE and can grant again on the next cycle.
            if (!d_we) begin
              owner_is_data_d = 1'b1;
              cnt_d           = CNT_LOAD;
              state_d         = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            // The return goes to the owner recorded at grant time. The
            // request lines are not looked at here.
            if (owner_is_data_q) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
